// File: rtl/sipo_deser.sv
// Serial-in/parallel-out deserializer: reassembles IN_W-bit valid/ready slices (MSB-first,
// framed by 'last') into OUT_W-bit words with a slice count and framing-error flag.
module sipo_deser #(
   parameter int unsigned IN_W  = 2,
   parameter int unsigned OUT_W = 8,
   localparam int unsigned RATIO = OUT_W / IN_W,
   localparam int unsigned CW    = $clog2(RATIO + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [IN_W-1:0]  din_data,
   input  logic             din_valid,
   input  logic             din_last,
   output logic             din_ready,
   output logic [OUT_W-1:0] dout_data,
   output logic             dout_valid,
   input  logic             dout_ready,
   output logic [CW-1:0]    dout_beats,
   output logic             dout_err
);

   if ((OUT_W % IN_W) != 0) begin : g_bad_ratio
      $error("sipo_deser: OUT_W must be a multiple of IN_W");
   end

   logic [OUT_W-1:0] shreg;
   logic [OUT_W-1:0] merged;
   logic [CW-1:0]    cnt;
   logic             slice_acc;
   logic             last_pos;
   logic             complete;

   // A held word blocks new slices unless the sink is taking it this cycle
   assign din_ready = !dout_valid | dout_ready;
   assign slice_acc = din_valid & din_ready;
   assign last_pos  = (cnt == CW'(RATIO - 1));
   assign complete  = slice_acc & (last_pos | din_last);

   // Place the incoming slice at its word position so short words stay left-justified
   always_comb begin
      merged = shreg;
      for (int unsigned i = 0; i < RATIO; i++) begin
         if (cnt == CW'(i)) begin
            merged[OUT_W-1-i*IN_W -: IN_W] = din_data;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         shreg      <= '0;
         cnt        <= '0;
         dout_data  <= '0;
         dout_valid <= 1'b0;
         dout_beats <= '0;
         dout_err   <= 1'b0;
      end else begin
         if (complete) begin
            dout_data  <= merged;
            dout_beats <= cnt + CW'(1);
            dout_err   <= !(last_pos & din_last);
            dout_valid <= 1'b1;
            shreg      <= '0;
            cnt        <= '0;
         end else begin
            if (slice_acc) begin
               shreg <= merged;
               cnt   <= cnt + CW'(1);
            end
            if (dout_ready) begin
               dout_valid <= 1'b0;
            end
         end
      end
   end

endmodule
